// File: rtl/ppm_pkg.sv
// Shared types and default constants for the pulse period meter.
// Imported by ppm_edge_det and pulse_period_meter.
package ppm_pkg;

   localparam int PPM_CNT_W  = 16;
   localparam int PPM_LOCK_N = 2;

   typedef enum logic {
      PPM_IDLE = 1'b0,
      PPM_MEAS = 1'b1
   } ppm_state_e;

endpackage

// File: rtl/ppm_edge_det.sv
// Rising-edge detector for pulse_in with a registered one-cycle rise pulse.
// Define PPM_SYNC_EN to add a 2-flop synchronizer ahead of the detector.
module ppm_edge_det
   import ppm_pkg::*;
(
   input  logic sys_clk,
   input  logic sys_rst_n,
   input  logic pulse_in,
   output logic rise
);

   logic sample;
   logic prev_q, prev_d;
   logic rise_q, rise_d;

`ifdef PPM_SYNC_EN
   logic [1:0] sync_q, sync_d;

   always_comb begin
      sync_d = {sync_q[0], pulse_in};
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign sample = sync_q[1];
`else
   assign sample = pulse_in;
`endif

   // The rise pulse is registered so downstream logic sees a clean one-cycle strobe.
   always_comb begin
      prev_d = sample;
      rise_d = sample & ~prev_q;
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         prev_q <= 1'b0;
         rise_q <= 1'b0;
      end else begin
         prev_q <= prev_d;
         rise_q <= rise_d;
      end
   end

   assign rise = rise_q;

endmodule

// File: rtl/pulse_period_meter.sv
// Measures rising-edge-to-rising-edge distance of pulse_in in sys_clk cycles,
// with lock and timeout flags. PPM_SYNC_EN enables the input synchronizer.
module pulse_period_meter
   import ppm_pkg::*;
#(
   parameter int CNT_W   = PPM_CNT_W,
   parameter int TIMEOUT = 2**CNT_W - 1,
   parameter int LOCK_N  = PPM_LOCK_N
) (
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   input  logic             pulse_in,
   output logic [CNT_W-1:0] period,
   output logic             period_vld,
   output logic             lock,
   output logic             timeout
);

   localparam int                 MATCH_W   = $clog2(LOCK_N);
   localparam logic [CNT_W-1:0]   TIMEOUT_C = CNT_W'(TIMEOUT);
   localparam logic [MATCH_W-1:0] MATCH_MAX = MATCH_W'(LOCK_N - 1);

   logic rise;

   ppm_edge_det u_edge_det (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .pulse_in  (pulse_in),
      .rise      (rise)
   );

   ppm_state_e         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [CNT_W-1:0]   period_q, period_d;
   logic               period_vld_q, period_vld_d;
   logic               lock_q, lock_d;
   logic               timeout_q, timeout_d;
   logic [MATCH_W-1:0] match_q, match_d;
   logic               have_prev_q, have_prev_d;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      period_d     = period_q;
      period_vld_d = 1'b0;
      lock_d       = lock_q;
      timeout_d    = timeout_q;
      match_d      = match_q;
      have_prev_d  = have_prev_q;

      case (state_q)
         PPM_IDLE: begin
            if (rise) begin
               cnt_d   = CNT_W'(1);
               state_d = PPM_MEAS;
            end
         end
         PPM_MEAS: begin
            // An edge wins over a coincident timeout, so cnt == TIMEOUT is still measured.
            if (rise) begin
               period_d     = cnt_q;
               period_vld_d = 1'b1;
               timeout_d    = 1'b0;
               cnt_d        = CNT_W'(1);
               have_prev_d  = 1'b1;
               if (have_prev_q && (cnt_q == period_q)) begin
                  match_d = (match_q == MATCH_MAX) ? match_q : match_q + MATCH_W'(1);
                  lock_d  = (match_d == MATCH_MAX);
               end else begin
                  match_d = '0;
                  lock_d  = 1'b0;
               end
            end else if (cnt_q == TIMEOUT_C) begin
               state_d     = PPM_IDLE;
               cnt_d       = '0;
               timeout_d   = 1'b1;
               lock_d      = 1'b0;
               match_d     = '0;
               have_prev_d = 1'b0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = PPM_IDLE;
         end
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q      <= PPM_IDLE;
         cnt_q        <= '0;
         period_q     <= '0;
         period_vld_q <= 1'b0;
         lock_q       <= 1'b0;
         timeout_q    <= 1'b0;
         match_q      <= '0;
         have_prev_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         period_q     <= period_d;
         period_vld_q <= period_vld_d;
         lock_q       <= lock_d;
         timeout_q    <= timeout_d;
         match_q      <= match_d;
         have_prev_q  <= have_prev_d;
      end
   end

   assign period     = period_q;
   assign period_vld = period_vld_q;
   assign lock       = lock_q;
   assign timeout    = timeout_q;

endmodule

// File: tb/tb_pulse_period_meter.sv
// Directed bench for pulse_period_meter with TIMEOUT = 20 and LOCK_N = 2.
module tb_pulse_period_meter;

   localparam int CNT_W = 16;

   logic             sys_clk;
   logic             sys_rst_n;
   logic             pulse_in;
   logic [CNT_W-1:0] period;
   logic             period_vld;
   logic             lock;
   logic             timeout;

   int n_checks;
   int n_fail;

   pulse_period_meter #(
      .CNT_W   (CNT_W),
      .TIMEOUT (20),
      .LOCK_N  (2)
   ) dut (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .pulse_in   (pulse_in),
      .period     (period),
      .period_vld (period_vld),
      .lock       (lock),
      .timeout    (timeout)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed no end of test, expected finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Drive one sample, let one posedge pass, settle 1 time unit past it.
   task automatic tick(input logic v);
      pulse_in = v;
      @(posedge sys_clk);
      #1;
   endtask

   // One pulse followed by p-1 low cycles; checks the strobe for this pulse and its absence elsewhere.
   task automatic pulse_chk(input int p, input logic exp_vld, input logic [CNT_W-1:0] exp_period,
                            input logic exp_lock, input string tag);
      int extra;
      tick(1'b1);
      extra = period_vld ? 1 : 0;
      tick(1'b0);
      chk({tag, ".vld"}, {31'd0, period_vld}, {31'd0, exp_vld});
      if (exp_vld) begin
         chk({tag, ".period"}, {16'd0, period}, {16'd0, exp_period});
         chk({tag, ".lock"}, {31'd0, lock}, {31'd0, exp_lock});
      end
      for (int i = 0; i < p - 2; i++) begin
         tick(1'b0);
         if (period_vld) extra++;
      end
      chk({tag, ".spacing"}, extra, 0);
   endtask

   initial begin
      int vld_cnt;
      n_checks  = 0;
      n_fail    = 0;
      pulse_in  = 1'b0;
      sys_rst_n = 1'b0;
      repeat (2) @(posedge sys_clk);
      #1;
      chk("rst.period", {16'd0, period}, 0);
      chk("rst.vld", {31'd0, period_vld}, 0);
      chk("rst.lock", {31'd0, lock}, 0);
      chk("rst.timeout", {31'd0, timeout}, 0);
      sys_rst_n = 1'b1;
      repeat (3) tick(1'b0);

      // Divide-by-6 strobe: lock on the second measurement.
      pulse_chk(6, 1'b0, 16'd0, 1'b0, "div6.e1");
      pulse_chk(6, 1'b1, 16'd6, 1'b0, "div6.e2");
      pulse_chk(6, 1'b1, 16'd6, 1'b1, "div6.e3");
      pulse_chk(6, 1'b1, 16'd6, 1'b1, "div6.e4");

      // Minimum period 2, then switch to 1-in-5.
      pulse_chk(2, 1'b1, 16'd6, 1'b1, "p2.e1");
      pulse_chk(2, 1'b1, 16'd2, 1'b0, "p2.e2");
      pulse_chk(2, 1'b1, 16'd2, 1'b1, "p2.e3");
      pulse_chk(2, 1'b1, 16'd2, 1'b1, "p2.e4");
      pulse_chk(5, 1'b1, 16'd2, 1'b1, "p5.e1");
      pulse_chk(5, 1'b1, 16'd5, 1'b0, "p5.e2");
      pulse_chk(5, 1'b1, 16'd5, 1'b1, "p5.e3");

      // Steady 6-cycle train, then stop: timeout after TIMEOUT+1 cycles.
      pulse_chk(6, 1'b1, 16'd5, 1'b1, "to.e1");
      pulse_chk(6, 1'b1, 16'd6, 1'b0, "to.e2");
      pulse_chk(6, 1'b1, 16'd6, 1'b1, "to.e3");
      repeat (15) tick(1'b0);
      chk("to.before", {31'd0, timeout}, 0);
      tick(1'b0);
      chk("to.timeout", {31'd0, timeout}, 1);
      chk("to.lock", {31'd0, lock}, 0);
      chk("to.period_hold", {16'd0, period}, 6);
      chk("to.vld", {31'd0, period_vld}, 0);
      repeat (4) tick(1'b0);
      pulse_chk(6, 1'b0, 16'd0, 1'b0, "restart.e1");
      chk("restart.timeout_held", {31'd0, timeout}, 1);
      pulse_chk(6, 1'b1, 16'd6, 1'b0, "restart.e2");
      chk("restart.timeout_clr", {31'd0, timeout}, 0);

      // Edge coinciding with cnt == TIMEOUT is a measurement, not a timeout.
      pulse_chk(20, 1'b1, 16'd6, 1'b1, "edge_at_to.e1");
      pulse_chk(20, 1'b1, 16'd20, 1'b0, "edge_at_to.e2");
      chk("edge_at_to.timeout", {31'd0, timeout}, 0);
      pulse_chk(6, 1'b1, 16'd20, 1'b1, "edge_at_to.e3");

      // Reset mid-period on a locked 6-cycle train.
      pulse_chk(6, 1'b1, 16'd6, 1'b0, "mid_rst.e1");
      pulse_chk(6, 1'b1, 16'd6, 1'b1, "mid_rst.e2");
      tick(1'b1);
      tick(1'b0);
      tick(1'b0);
      chk("mid_rst.pre_lock", {31'd0, lock}, 1);
      #2 sys_rst_n = 1'b0;
      #1;
      chk("mid_rst.period", {16'd0, period}, 0);
      chk("mid_rst.lock", {31'd0, lock}, 0);
      chk("mid_rst.vld", {31'd0, period_vld}, 0);
      chk("mid_rst.timeout", {31'd0, timeout}, 0);
      @(posedge sys_clk);
      #1 sys_rst_n = 1'b1;
      repeat (2) tick(1'b0);
      pulse_chk(6, 1'b0, 16'd0, 1'b0, "post_rst.e1");
      pulse_chk(6, 1'b1, 16'd6, 1'b0, "post_rst.e2");

      // pulse_in stuck high: one edge only, so no measurement and a timeout.
      sys_rst_n = 1'b0;
      tick(1'b0);
      sys_rst_n = 1'b1;
      tick(1'b0);
      vld_cnt = 0;
      for (int i = 0; i < 50; i++) begin
         tick(1'b1);
         if (period_vld) vld_cnt++;
      end
      chk("stuck_high.vld_count", vld_cnt, 0);
      chk("stuck_high.timeout", {31'd0, timeout}, 1);
      chk("stuck_high.lock", {31'd0, lock}, 0);
      chk("stuck_high.period", {16'd0, period}, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pulse_period_meter.md
# pulse_period_meter

Measures the interval, in sys_clk cycles, between consecutive rising edges of a pulse train such as a divided clock-enable strobe. It is the consuming end of the team's clock-divider blocks. It reports each measured period with a one-cycle valid strobe, flags lock once the period is stable, and flags timeout when the pulse train stops. It sits next to divider outputs and external tick inputs for self-check and frequency monitoring.

## Interface
- CNT_W, 16: width of the period counter and the period output.
- TIMEOUT, 2**CNT_W-1: cycle count with no edge that triggers timeout. Must satisfy 2 ≤ TIMEOUT ≤ 2**CNT_W-1.
- LOCK_N, 2: number of consecutive identical measurements required for lock. Minimum 2.
- sys_clk  in  1  clock; all logic on posedge.
- sys_rst_n  in  1  reset, asynchronous, active-low.
- pulse_in  in  1  monitored pulse train, level-sampled.
- period  out  CNT_W  last measured rising-edge-to-rising-edge distance in sys_clk cycles.
- period_vld  out  1  one-cycle strobe; period is updated in the same cycle.
- lock  out  1  level; high after LOCK_N consecutive equal periods.
- timeout  out  1  level; high while no edge arrived within TIMEOUT cycles.

## Operation
- Rising edge: the current sample of pulse_in is 1 and the previous registered sample is 0. Continuous high and continuous low both produce no edges.
- State machine, 2 states:
  - IDLE: entered at reset and on timeout. On an edge: cnt <= 1, go to MEAS. No period_vld is produced for this first edge.
  - MEAS: cnt increments every cycle.
    - On an edge: period <= cnt, period_vld <= 1, timeout <= 0, cnt <= 1, stay in MEAS.
    - With no edge and cnt == TIMEOUT: go to IDLE, timeout <= 1, lock <= 0, match count <= 0. period holds its last value.
- An edge in the same cycle that cnt == TIMEOUT is a valid measurement. The edge takes priority and no timeout occurs.
- cnt never wraps, because the timeout check bounds it.
- The minimum measurable period is 2 (input pattern 1,0,1,0,...).
- Lock tracking:
  - On each measurement, compare the new period with the previous period.
  - Equal: match count increments, saturating at LOCK_N-1.
  - Unequal: match count <= 0 and lock <= 0, both in the period_vld cycle.
  - lock <= 1 in the period_vld cycle where the match count reaches LOCK_N-1.
  - The first measurement after IDLE has no predecessor and counts as a mismatch.
- Reset mid-measurement discards the partial count. Every register returns to its reset value.

## Timing
- Reset values: period = 0, period_vld = 0, lock = 0, timeout = 0, state IDLE, cnt = 0.
- Latency: period_vld rises 2 sys_clk cycles after the cycle in which pulse_in is first sampled high (1 cycle for the sample register, 1 for the output register). Add 2 cycles when PPM_SYNC_EN is defined.
- A steady train yields period_vld exactly once per period, spaced by that period.
- timeout asserts TIMEOUT+1 cycles after the last edge's cnt <= 1 cycle, measured at the output register. It deasserts together with the next period_vld, which needs two edges: one to leave IDLE and one to measure.

## Configuration
- PPM_SYNC_EN defined: pulse_in passes through a 2-flop synchronizer before edge detection. Use this when pulse_in is asynchronous to sys_clk. Latency increases by 2 cycles and measured periods are unchanged.
- PPM_SYNC_EN undefined: pulse_in must be synchronous to sys_clk and is sampled directly.

## Structure
- Package ppm_pkg contains:
  - the state typedef (PPM_IDLE, PPM_MEAS);
  - the default constants PPM_CNT_W = 16 and PPM_LOCK_N = 2.
- Sub-module ppm_edge_det holds the optional synchronizer and the rising-edge detector. Its output is a one-cycle rise pulse.
- Top level holds the FSM, the counter, the lock logic and the output registers.

## Test plan
- Strobe high 1 cycle in every 6 (output of a divide-by-6) → period = 6 on each period_vld, period_vld spaced 6 cycles apart, lock rises on the 2nd period_vld with LOCK_N = 2.
- Pattern 1,0 repeating → period = 2 every 2 cycles. Then switch to 1-in-5 → first period_vld reports 5 with lock = 0, next one reports 5 with lock = 1.
- TIMEOUT = 20 and pulse_in stops after a steady 6-cycle train → timeout = 1 and lock = 0 at the expected cycle, period holds 6. Restart the train → first edge gives no period_vld, second edge gives period_vld with period = 6 and timeout = 0.
- Edge arriving exactly when cnt == TIMEOUT → period = TIMEOUT, period_vld = 1, timeout stays 0.
- pulse_in held high for 50 cycles with TIMEOUT = 20 → no period_vld, timeout = 1.
- sys_rst_n asserted for 1 cycle mid-period on a locked 6-cycle train → all outputs return to 0 immediately. After release, first period_vld appears only after the second post-reset edge, with period = 6.
